// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the CPU control FSM: opcodes, ALU codes, states and
// the decoded control bundle passed from ctrl_decode to the sequencer.
package cpu_ctrl_fsm_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'h33;
    localparam logic [6:0] OPC_ADDI  = 7'h13;
    localparam logic [6:0] OPC_LW    = 7'h03;
    localparam logic [6:0] OPC_SW    = 7'h23;
    localparam logic [6:0] OPC_BEQ   = 7'h63;
    localparam logic [6:0] OPC_JAL   = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    // use_mem routes EXEC to MEM; is_beq makes EXEC the last state.
    typedef struct packed {
        logic       alu_src;
        logic [2:0] op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic       use_mem;
        logic       is_beq;
        logic       is_jal;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_fsm_ctrl_decode.sv
// Combinational opcode-to-control mapping; unknown opcodes decode as an
// illegal NOP that still takes the EXEC->WB path with no write strobes.
module ctrl_decode
    import cpu_ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.alu_src = 1'b1;
        ctrl.op      = ALU_ADD;
        case (opcode)
            OPC_RTYPE: begin
                ctrl.alu_src   = 1'b0;
                ctrl.reg_write = 1'b1;
            end
            OPC_ADDI: begin
                ctrl.reg_write = 1'b1;
            end
            OPC_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.mem2reg   = 1'b1;
                ctrl.use_mem   = 1'b1;
            end
            OPC_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.use_mem   = 1'b1;
            end
            OPC_BEQ: begin
                ctrl.alu_src = 1'b0;
                ctrl.op      = ALU_SUB;
                ctrl.is_beq  = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.is_jal    = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: walks each instruction through its states,
// owns the PC, instruction register and retire counter, and drives control.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter logic [31:0] ENTRY_PC = 32'h28,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] max_count,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic [31:0]      imm,
    input  logic [31:0]      jTarget,
    output logic [31:0]      PCin,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic [2:0]       op,
    output logic             fetch_en,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state;
    state_t           state_n;
    logic [31:0]      ir;
    logic [31:0]      ir_n;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] retired_inc;
    logic [31:0]      pc_next;
    logic             retire;
    logic             launch;
    logic             in_instr;
    logic             reg_write_q;
    logic             mem_write_q;
    ctrl_t            dec;
    logic             unused_ir_hi;

    // Decode the word that will sit in ir next cycle, so registered control
    // outputs are already valid in the first DECODE cycle.
    assign ir_n = (state == S_FETCH) ? ins : ir;

    ctrl_decode u_decode (
        .opcode (ir_n[6:0]),
        .ctrl   (dec)
    );

    assign unused_ir_hi = ^ir[31:7];

    assign retired_inc = (&retired) ? retired : retired + 1'b1;

    always_comb begin
        if (dec.is_beq && zero)
            pc_next = PCin + (imm << 1);
        else if (dec.is_jal)
            pc_next = PCin + (jTarget << 2);
        else
            pc_next = PCin + 32'd4;
    end

    always_comb begin
        state_n = state;
        retire  = 1'b0;
        launch  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_FETCH;
                    launch  = 1'b1;
                end
            end
            S_FETCH:  state_n = (max_q == '0) ? S_DONE : S_DECODE;
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                if (dec.is_beq)
                    retire = 1'b1;
                else if (dec.use_mem)
                    state_n = S_MEM;
                else
                    state_n = S_WB;
            end
            S_MEM: begin
                if (dec.mem_write)
                    retire = 1'b1;
                else
                    state_n = S_WB;
            end
            S_WB:     retire = 1'b1;
            default:  state_n = S_IDLE;
        endcase
        if (retire)
            state_n = (retired_inc == max_q) ? S_DONE : S_FETCH;
    end

    assign in_instr = (state_n == S_DECODE) || (state_n == S_EXEC) ||
                      (state_n == S_MEM)    || (state_n == S_WB);

    // Outputs are registered from the next state, so they line up with the
    // state they describe rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            max_q       <= '0;
            PCin        <= ENTRY_PC;
            retired     <= '0;
            fetch_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            ALUSrc      <= 1'b1;
            op          <= ALU_ADD;
            MemRead     <= 1'b0;
            Mem2Reg     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            if (launch) begin
                PCin    <= ENTRY_PC;
                retired <= '0;
                max_q   <= max_count;
            end
            if (retire) begin
                PCin    <= pc_next;
                retired <= retired_inc;
            end
            fetch_en    <= (state_n == S_FETCH) && (launch ? (max_count != '0) : 1'b1);
            busy        <= (state_n != S_IDLE) && (state_n != S_DONE);
            done        <= (state_n == S_DONE);
            illegal     <= (state_n == S_DECODE) && dec.illegal;
            ALUSrc      <= in_instr ? dec.alu_src : 1'b1;
            op          <= in_instr ? dec.op : ALU_ADD;
            MemRead     <= ((state_n == S_MEM) || (state_n == S_WB)) && dec.mem_read;
            Mem2Reg     <= (state_n == S_WB) && dec.mem2reg;
            reg_write_q <= (state_n == S_WB) && dec.reg_write;
            mem_write_q <= (state_n == S_MEM) && dec.mem_write;
        end
    end

    // A reset landing in MEM or WB must kill the write in that same cycle.
    assign RegWrite = reg_write_q & ~rst;
    assign MemWrite = mem_write_q & ~rst;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm: runs short programs and
// compares cycle counts, strobe counts, PC and retire count to hand values.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] max_count;
    logic [31:0] ins;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] jTarget;
    logic [31:0] PCin;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        Mem2Reg;
    logic [2:0]  op;
    logic        fetch_en;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [4];

    typedef struct {
        int cycles;
        int nFetch;
        int nRegW;
        int nMemW;
        int nMemR;
        int nM2R;
        int nIll;
        int regWCycle;
        int memWCycle;
        int decOp;
        int decAluSrc;
    } trace_t;

    trace_t tr;

    cpu_ctrl_fsm #(.ENTRY_PC(32'h28), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .max_count (max_count),
        .ins       (ins),
        .zero      (zero),
        .imm       (imm),
        .jTarget   (jTarget),
        .PCin      (PCin),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Mem2Reg   (Mem2Reg),
        .op        (op),
        .fetch_en  (fetch_en),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] m);
        start     = s;
        max_count = m;
    endtask

    // Starts a run and follows it to DONE, feeding prog[] on each fetch strobe.
    task automatic runProgram(input logic [15:0] maxc, input int pokeAt, output trace_t t);
        int fi;
        t  = '{default: 0};
        fi = 0;
        applyStimulus(1'b1, maxc);
        step();
        applyStimulus(1'b0, 16'hFFFF);
        while (!done && t.cycles < 40) begin
            t.cycles++;
            if (fetch_en) begin
                t.nFetch++;
                if (fi < 4) ins = prog[fi];
                fi++;
            end
            if (RegWrite) begin
                t.nRegW++;
                t.regWCycle = t.cycles;
            end
            if (MemWrite) begin
                t.nMemW++;
                t.memWCycle = t.cycles;
            end
            if (MemRead) t.nMemR++;
            if (Mem2Reg) t.nM2R++;
            if (illegal) t.nIll++;
            if (t.cycles == 2) begin
                t.decOp     = int'(op);
                t.decAluSrc = int'(ALUSrc);
            end
            start = (t.cycles == pokeAt);
            step();
        end
        start = 1'b0;
        checkOutput("run_reaches_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; max_count = '0; ins = '0;
        zero = 1'b0; imm = '0; jTarget = '0;
        prog[0] = 32'h0; prog[1] = 32'h0; prog[2] = 32'h0; prog[3] = 32'h0;
        step();
        step();
        rst = 1'b0;

        checkOutput("rst_pc", PCin, 32'h28);
        checkOutput("rst_retired", {16'd0, retired}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_fetch", {31'd0, fetch_en}, 32'd0);
        checkOutput("rst_alusrc", {31'd0, ALUSrc}, 32'd1);
        checkOutput("rst_op", {29'd0, op}, 32'h2);
        checkOutput("rst_regw", {31'd0, RegWrite}, 32'd0);

        // add, one instruction
        prog[0] = 32'h0000_0033;
        runProgram(16'd1, 0, tr);
        checkOutput("add_cycles", tr.cycles, 4);
        checkOutput("add_fetch", tr.nFetch, 1);
        checkOutput("add_regw_n", tr.nRegW, 1);
        checkOutput("add_regw_cyc", tr.regWCycle, 4);
        checkOutput("add_dec_alusrc", tr.decAluSrc, 0);
        checkOutput("add_pc", PCin, 32'h2C);
        checkOutput("add_retired", {16'd0, retired}, 32'd1);
        checkOutput("add_busy", {31'd0, busy}, 32'd0);

        // beq taken, restarted from DONE
        prog[0] = 32'h0000_0063; zero = 1'b1; imm = 32'd8;
        runProgram(16'd1, 0, tr);
        checkOutput("beqt_cycles", tr.cycles, 3);
        checkOutput("beqt_pc", PCin, 32'h38);
        checkOutput("beqt_dec_op", tr.decOp, 32'h6);
        checkOutput("beqt_dec_alusrc", tr.decAluSrc, 0);
        checkOutput("beqt_writes", tr.nRegW + tr.nMemW, 0);

        // beq not taken
        zero = 1'b0;
        runProgram(16'd1, 0, tr);
        checkOutput("beqn_pc", PCin, 32'h2C);
        checkOutput("beqn_cycles", tr.cycles, 3);

        // lw then sw, with a start pulse mid-run that must be ignored
        prog[0] = 32'h0000_0003; prog[1] = 32'h0000_0023;
        runProgram(16'd2, 3, tr);
        checkOutput("lwsw_cycles", tr.cycles, 9);
        checkOutput("lwsw_memr", tr.nMemR, 2);
        checkOutput("lwsw_m2r", tr.nM2R, 1);
        checkOutput("lwsw_memw_n", tr.nMemW, 1);
        checkOutput("lwsw_memw_cyc", tr.memWCycle, 9);
        checkOutput("lwsw_regw", tr.nRegW, 1);
        checkOutput("lwsw_fetch", tr.nFetch, 2);
        checkOutput("lwsw_retired", {16'd0, retired}, 32'd2);
        checkOutput("lwsw_pc", PCin, 32'h30);

        // jal with wrap-around offset
        prog[0] = 32'h0000_006F; jTarget = 32'hFFFF_FFFF;
        runProgram(16'd1, 0, tr);
        checkOutput("jal_pc", PCin, 32'h24);
        checkOutput("jal_cycles", tr.cycles, 4);
        checkOutput("jal_regw", tr.nRegW, 1);

        // unknown opcode behaves as an illegal NOP
        prog[0] = 32'h0000_007F;
        runProgram(16'd1, 0, tr);
        checkOutput("nop_ill", tr.nIll, 1);
        checkOutput("nop_cycles", tr.cycles, 4);
        checkOutput("nop_writes", tr.nRegW + tr.nMemW, 0);
        checkOutput("nop_pc", PCin, 32'h2C);
        checkOutput("nop_retired", {16'd0, retired}, 32'd1);

        // zero budget
        runProgram(16'd0, 0, tr);
        checkOutput("zero_cycles", tr.cycles, 1);
        checkOutput("zero_fetch", tr.nFetch, 0);
        checkOutput("zero_retired", {16'd0, retired}, 32'd0);
        checkOutput("zero_pc", PCin, 32'h28);

        // reset during MEM of sw aborts the store
        ins = 32'h0000_0023;
        applyStimulus(1'b1, 16'd1);
        step();
        applyStimulus(1'b0, 16'd1);
        step();
        step();
        step();
        checkOutput("swrst_memw_pre", {31'd0, MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("swrst_memw_gated", {31'd0, MemWrite}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("swrst_memw_after", {31'd0, MemWrite}, 32'd0);
        checkOutput("swrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("swrst_done", {31'd0, done}, 32'd0);
        checkOutput("swrst_pc", PCin, 32'h28);
        step();
        checkOutput("swrst_idle_stays", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
